// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared constants for the nibble-serial adder controller:
//   SLICE_W            width of one adder slice (bits)
//   ST_IDLE/RUN/DONE   FSM state encoding used by serial_add_ctrl
//   idx_width()        width of the slice index counter for a given slice count
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int SLICE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ceil(log2(n)) with a floor of one bit, so a single-slice build still
    // has a legal counter.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/ripplecarryadd.sv
// ---------------------------------------------------------------------------
// ripplecarryadd
// Purely combinational 4-bit ripple-carry adder.
// Ports:
//   A, B  in   4-bit addends
//   C     in   carry-in
//   S     out  4-bit sum
//   D     out  carry-out
// ---------------------------------------------------------------------------
module ripplecarryadd (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C,
    output logic [3:0] S,
    output logic       D
);

    always_comb begin : ripple
        logic carry;
        S     = '0;
        carry = C;
        for (int i = 0; i < 4; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        D = carry;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Adds two W-bit operands (W = 4*NIBBLES) one nibble per clock through a
// single 4-bit ripple-carry slice, least-significant nibble first.
//
// Handshake: start is sampled only while ready (state IDLE or DONE); the
// accepting edge captures a/b/cin. busy is high for exactly NIBBLES cycles,
// then done pulses for one cycle with sum/cout final. A start seen during the
// DONE cycle begins the next addition immediately (back-to-back). start
// during RUN is ignored.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   begin an addition (when ready)
//   a, b       in   W-bit operands
//   cin        in   carry-in
//   busy       out  high while slices are being processed (state RUN)
//   done       out  one-cycle pulse when sum/cout are final (state DONE)
//   sum        out  W-bit result register
//   cout       out  final carry-out
//   dbg_state  out  registered FSM state (adder_pkg encoding)
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [SLICE_W*NIBBLES-1:0]   a,
    input  logic [SLICE_W*NIBBLES-1:0]   b,
    input  logic                         cin,
    output logic                         busy,
    output logic                         done,
    output logic [SLICE_W*NIBBLES-1:0]   sum,
    output logic                         cout,
    output logic [1:0]                   dbg_state
);

    localparam int W     = SLICE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;
    logic [W-1:0]     sum_q,   sum_d;
    logic             cout_q,  cout_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_c;
    logic               ready;

    assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

    ripplecarryadd u_slice (
        .A (slice_a),
        .B (slice_b),
        .C (carry_q),
        .S (slice_s),
        .D (slice_c)
    );

    assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_RUN: begin
                sum_d[idx_q*SLICE_W +: SLICE_W] = slice_s;
                carry_d = slice_c;
                if (idx_q == LAST_IDX) begin
                    // Final slice: publish the carry and park the index at 0
                    // so it never leaves the 0..NIBBLES-1 range.
                    state_d = ST_DONE;
                    cout_d  = slice_c;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;   // IDLE, and recovery from code 3
        endcase

        // Accepting start overrides the DONE->IDLE step, giving back-to-back
        // operation. cout keeps the previous result until the new one lands.
        if (start && ready) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            sum_d   = '0;
            idx_d   = '0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign dbg_state = state_q;

endmodule
